// File: rtl/sram_arb_pkg.sv
// Shared types for the sram port arbiter.
//   state_e : arbiter FSM state (INIT = zero-fill sweep, RUN = arbitration)
//   resp_t  : one stage of the read-response pipe {valid, requester index}
//   idx_w() : width of a binary port index, never less than 1
package sram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Response index is carried at a fixed width so the struct can live in the
  // package; the top level zero-extends its narrower index into it.
  localparam int MAX_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } resp_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Round-robin pointer plus priority pick.
//   clk_i, rst_ni : clock, async active-low reset
//   i_req         : per-port request
//   i_advance     : a grant is being taken this cycle, move the pointer
//   o_gnt         : one-hot grant (zero when nothing requests)
//   o_idx         : binary index of the granted port
// The pick is the first requesting port at or after the pointer, wrapping.
module sram_arb_rr
  import sram_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_advance,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IDX_W-1:0]     o_idx
);

  logic [IDX_W-1:0]     r_ptr;
  logic [NUM_PORTS-1:0] w_rot;
  logic                 w_found;
  int                   w_sum;

  // Rotate requests so the pointer's port lands on bit 0, take the lowest
  // set bit, then rotate the position back into absolute port numbering.
  always_comb begin
    w_rot   = NUM_PORTS'({i_req, i_req} >> r_ptr);
    w_found = 1'b0;
    w_sum   = int'(r_ptr);
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = int'(r_ptr) + k;
      end
    end
    if (w_sum >= NUM_PORTS) w_sum = w_sum - NUM_PORTS;
    o_idx = IDX_W'(w_sum);
    o_gnt = w_found ? (NUM_PORTS'(1) << o_idx) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port sram between NUM_PORTS requesters.
//   clk_i, rst_ni           : clock, async active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i : per-port request fields, packed [port][field]
//   gnt_o                   : one-hot grant, combinational, same cycle as request
//   rvalid_o                : read data valid for that port, RD_LAT after grant
//   rdata_o                 : read data shared by all ports (= sram_rdata_i)
//   init_done_o             : high in RUN (after the optional zero-fill sweep)
//   sram_*_o / sram_rdata_i : single-port sram interface
//   dbg_state_o             : current FSM state
// Handshake: a requester raises req with its fields and holds them until the
// cycle gnt is high; that cycle is the whole transfer, so a port may be
// granted every cycle. Reads answer with rvalid exactly RD_LAT cycles later.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_WORDS  = 1024,
  parameter  int OUT_REGS   = 0,
  parameter  int INIT_ZERO  = 0,
  localparam int ADDR_W     = $clog2(NUM_WORDS),
  localparam int BE_W       = (DATA_WIDTH + 7) / 8,
  localparam int RD_LAT     = 1 + OUT_REGS,
  localparam int IDX_W      = idx_w(NUM_PORTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BE_W-1:0]       be_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            init_done_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [ADDR_W-1:0]               sram_addr_o,
  output logic [DATA_WIDTH-1:0]           sram_wdata_o,
  output logic [BE_W-1:0]                 sram_be_o,
  input  logic [DATA_WIDTH-1:0]           sram_rdata_i,
  output state_e                          dbg_state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_e                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_init_cnt;
  resp_t                 r_pipe [RD_LAT];
  logic [NUM_PORTS-1:0]  w_gnt;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_advance;
  logic                  w_rd_issue;

  logic                  w_we_arr    [NUM_PORTS];
  logic [ADDR_W-1:0]     w_addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_PORTS];
  logic [BE_W-1:0]       w_be_arr    [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign w_we_arr[p]    = we_i[p];
    assign w_addr_arr[p]  = addr_i[p*ADDR_W +: ADDR_W];
    assign w_wdata_arr[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    assign w_be_arr[p]    = be_i[p*BE_W +: BE_W];
  end

  sram_arb_rr #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_req     (req_i),
    .i_advance (w_advance),
    .o_gnt     (w_gnt),
    .o_idx     (w_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= (INIT_ZERO != 0) ? INIT : RUN;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT && r_init_cnt != LAST_ADDR) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // All request-side outputs are qualified with rst_ni so that while reset is
  // held nothing is granted or issued, even though the decode is combinational.
  always_comb begin
    w_state_nxt  = r_state;
    gnt_o        = '0;
    init_done_o  = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    w_advance    = 1'b0;
    w_rd_issue   = 1'b0;
    case (r_state)
      INIT: begin
        sram_req_o  = rst_ni;
        sram_we_o   = rst_ni;
        sram_be_o   = '1;
        sram_addr_o = r_init_cnt;
        if (r_init_cnt == LAST_ADDR) w_state_nxt = RUN;
      end
      RUN: begin
        if (rst_ni) begin
          init_done_o  = 1'b1;
          gnt_o        = w_gnt;
          sram_req_o   = |req_i;
          sram_we_o    = w_we_arr[w_idx];
          sram_addr_o  = w_addr_arr[w_idx];
          sram_wdata_o = w_wdata_arr[w_idx];
          sram_be_o    = w_be_arr[w_idx];
          w_advance    = |req_i;
          w_rd_issue   = (|req_i) && !w_we_arr[w_idx];
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Response pipe: stage 0 captures the read issued this cycle, the last
  // stage lines up with the cycle the sram presents its data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0].valid <= w_rd_issue;
      r_pipe[0].idx   <= MAX_IDX_W'(w_idx);
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = r_pipe[RD_LAT-1].valid && (r_pipe[RD_LAT-1].idx == MAX_IDX_W'(p));
    end
  end

  assign rdata_o     = sram_rdata_i;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int NP = 3;
  localparam int DW = 64;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int BW = 8;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  logic [NP-1:0] req, we;
  logic [AW-1:0] addr  [NP];
  logic [DW-1:0] wdata [NP];
  logic [BW-1:0] be    [NP];
  logic [NP-1:0] gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o, sram_wdata_o;
  logic [DW-1:0] sram_rdata_i;
  logic          init_done_o, sram_req_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [BW-1:0] sram_be_o;
  state_e        dbg_state_o;

  sram_port_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW), .OUT_REGS(1), .INIT_ZERO(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req), .we_i(we),
    .addr_i({addr[2], addr[1], addr[0]}),
    .wdata_i({wdata[2], wdata[1], wdata[0]}),
    .be_i({be[2], be[1], be[0]}),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .init_done_o(init_done_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // Behavioural sram with one output register: read latency 2. Starts with
  // non-zero content so the zero-fill sweep is observable.
  logic [DW-1:0] sram_mem [NW] = '{default: 64'hA5A5_5A5A_C3C3_3C3C};
  logic [DW-1:0] sram_r1;
  always @(posedge clk) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < BW; b++)
          if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      end else begin
        sram_r1 <= sram_mem[sram_addr_o];
      end
    end
    sram_rdata_i <= sram_r1;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    int            due;
    logic [1:0]    port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          exp_q [$];
  logic [DW-1:0] mdl_mem [NW];
  int            mdl_ptr;
  int            cyc;
  int            last_g;
  logic [NP-1:0] seen_gnt;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Round robin by its definition: nearest requester at distance 0..NP-1 from ptr.
  function automatic int pick(input logic [NP-1:0] r, input int ptr);
    for (int d = 0; d < NP; d++)
      if (r[(ptr + d) % NP]) return (ptr + d) % NP;
    return -1;
  endfunction

  // One RUN cycle: check outputs mid-cycle, advance the model, cross the edge.
  task automatic do_cycle();
    int            g;
    logic [NP-1:0] exp_rv;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    exp_rv = '0;
    exp_d  = '0;
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      exp_rv[e.port] = 1'b1;
      exp_d = e.data;
    end
    chk("rvalid", rvalid_o, exp_rv);
    if (exp_rv != '0) chk("rdata", rdata_o, exp_d);
    chk("init_done", init_done_o, 1);
    g = pick(req, mdl_ptr);
    seen_gnt = gnt_o;
    chk("gnt", gnt_o, (g < 0) ? 0 : (1 << g));
    chk("sram_req", sram_req_o, |req);
    if (g >= 0) begin
      chk("sram_addr", sram_addr_o, addr[g]);
      chk("sram_we", sram_we_o, we[g]);
      if (we[g]) begin
        chk("sram_wdata", sram_wdata_o, wdata[g]);
        chk("sram_be", sram_be_o, be[g]);
        for (int b = 0; b < BW; b++)
          if (be[g][b]) mdl_mem[addr[g]][b*8 +: 8] = wdata[g][b*8 +: 8];
      end else begin
        exp_q.push_back('{due: cyc + LAT, port: 2'(g), data: mdl_mem[addr[g]]});
      end
      mdl_ptr = (g + 1) % NP;
    end
    last_g = g;
    tick();
  endtask

  task automatic init_check();
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk("init_req", sram_req_o, 1);
      chk("init_we", sram_we_o, 1);
      chk("init_addr", sram_addr_o, i);
      chk("init_wdata", sram_wdata_o, 0);
      chk("init_be", sram_be_o, 8'hFF);
      chk("init_gnt", gnt_o, 0);
      chk("init_done_low", init_done_o, 0);
      chk("init_rvalid", rvalid_o, 0);
      tick();
    end
    for (int a = 0; a < NW; a++) mdl_mem[a] = '0;
    mdl_ptr = 0;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_sram_req", sram_req_o, 0);
    chk("rst_rdata", rdata_o, sram_rdata_i);
  endtask

  task automatic set_all(input logic [NP-1:0] r, input logic [NP-1:0] w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] e);
    req = r;
    we  = w;
    for (int p = 0; p < NP; p++) begin
      addr[p] = a; wdata[p] = d; be[p] = e;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [NP-1:0] exp_gnt;
  } vec_t;
  vec_t tv [22];

  initial begin
    // all requesting from ptr 0: strict rotation
    tv[0]  = '{3'b111, 3'b000, 4'd0, 64'd0, 8'hFF, 3'b001};
    tv[1]  = '{3'b111, 3'b000, 4'd1, 64'd0, 8'hFF, 3'b010};
    tv[2]  = '{3'b111, 3'b000, 4'd2, 64'd0, 8'hFF, 3'b100};
    tv[3]  = '{3'b111, 3'b000, 4'd3, 64'd0, 8'hFF, 3'b001};
    tv[4]  = '{3'b111, 3'b000, 4'd4, 64'd0, 8'hFF, 3'b010};
    tv[5]  = '{3'b111, 3'b000, 4'd5, 64'd0, 8'hFF, 3'b100};
    // single requester port1, then again with ptr=2
    tv[6]  = '{3'b010, 3'b000, 4'd3, 64'd0, 8'hFF, 3'b010};
    tv[7]  = '{3'b010, 3'b000, 4'd4, 64'd0, 8'hFF, 3'b010};
    tv[8]  = '{3'b101, 3'b000, 4'd6, 64'd0, 8'hFF, 3'b100};
    // byte-enabled write then read back by port0
    tv[9]  = '{3'b010, 3'b010, 4'd5, 64'h0000_0000_DEAD_BEEF, 8'h0F, 3'b010};
    tv[10] = '{3'b001, 3'b000, 4'd5, 64'd0, 8'hFF, 3'b001};
    tv[11] = '{3'b000, 3'b000, 4'd0, 64'd0, 8'hFF, 3'b000};
    tv[12] = '{3'b011, 3'b000, 4'd1, 64'd0, 8'hFF, 3'b010};
    tv[13] = '{3'b000, 3'b000, 4'd0, 64'd0, 8'hFF, 3'b000};
    tv[14] = '{3'b000, 3'b000, 4'd0, 64'd0, 8'hFF, 3'b000};
    // distinct data, then back-to-back reads port0,1,0
    tv[15] = '{3'b001, 3'b001, 4'd8, 64'h1111_2222_3333_4444, 8'hFF, 3'b001};
    tv[16] = '{3'b010, 3'b010, 4'd9, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 3'b010};
    tv[17] = '{3'b001, 3'b000, 4'd8, 64'd0, 8'hFF, 3'b001};
    tv[18] = '{3'b010, 3'b000, 4'd9, 64'd0, 8'hFF, 3'b010};
    tv[19] = '{3'b001, 3'b000, 4'd5, 64'd0, 8'hFF, 3'b001};
    tv[20] = '{3'b000, 3'b000, 4'd0, 64'd0, 8'hFF, 3'b000};
    tv[21] = '{3'b000, 3'b000, 4'd0, 64'd0, 8'hFF, 3'b000};

    cyc = 0;
    last_g = -1;
    mdl_ptr = 0;
    set_all(3'b111, 3'b000, 4'd0, 64'd0, 8'hFF);

    // reset held with requests up: nothing must be granted
    repeat (2) @(posedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // zero-fill sweep with requests pending, then first RUN cycle serves them
    init_check();

    for (int i = 0; i < 22; i++) begin
      set_all(tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be);
      do_cycle();
      chk($sformatf("vec%0d_gnt", i), seen_gnt, tv[i].exp_gnt);
    end

    // every address reads its model contents (zero unless written above)
    for (int a = 0; a < NW; a++) begin
      set_all(3'b001, 3'b000, AW'(a), 64'd0, 8'hFF);
      do_cycle();
    end

    // randomized traffic; a port not granted keeps its request and fields
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req[p] && last_g != p)) begin
          req[p]   = ($urandom_range(0, 3) != 0);
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = AW'($urandom_range(0, NW - 1));
          wdata[p] = {$urandom, $urandom};
          be[p]    = BW'($urandom_range(0, 255));
        end
      end
      do_cycle();
    end
    set_all(3'b000, 3'b000, 4'd0, 64'd0, 8'hFF);
    repeat (3) do_cycle();

    // reset mid-flight: port2 read granted, reset the next cycle
    set_all(3'b100, 3'b000, 4'd7, 64'd0, 8'hFF);
    do_cycle();
    rst_ni = 1'b0;
    set_all(3'b111, 3'b000, 4'd2, 64'd0, 8'hFF);
    exp_q.delete();
    check_reset_outputs();
    tick();
    @(negedge clk);
    chk("rst_inflight_rvalid", rvalid_o, 0);
    tick();
    rst_ni = 1'b1;
    init_check();
    do_cycle();
    chk("post_reset_gnt", seen_gnt, 3'b001);
    set_all(3'b000, 3'b000, 4'd0, 64'd0, 8'hFF);
    repeat (3) do_cycle();
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
